// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package interrupt_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic [IDX_W-1:0] SW0   = 3'd0;
    localparam logic [IDX_W-1:0] SW1   = 3'd1;
    localparam logic [IDX_W-1:0] SW2   = 3'd2;
    localparam logic [IDX_W-1:0] SW3   = 3'd3;
    localparam logic [IDX_W-1:0] NORTH = 3'd4;
    localparam logic [IDX_W-1:0] SOUTH = 3'd5;
    localparam logic [IDX_W-1:0] EAST  = 3'd6;
    localparam logic [IDX_W-1:0] WEST  = 3'd7;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StService,
        StClear
    } irq_state_e;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational priority encoder: the lowest set request bit wins.
module irq_priority_enc
    import interrupt_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: masks and prioritises eight sources, runs the request/ack/done handshake.
// Define IRQ_TIMEOUT_EN to enable the acknowledge timeout and the sticky Timeout flag.
module interrupt_dispatcher
    import interrupt_pkg::*;
#(
    parameter logic [7:0]  RESET_MASK     = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [NUM_SRC-1:0] Src_State,
    input  logic               Mask_Write,
    input  logic [NUM_SRC-1:0] Mask_Data,
    input  logic               IRQ_Ack,
    input  logic               IRQ_Done,
    output logic               IRQ,
    output logic [IDX_W-1:0]   IRQ_Cause,
    output logic [NUM_SRC-1:0] Src_Clear,
    output logic [NUM_SRC-1:0] Pending,
    output logic               Busy,
    output logic               Timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    irq_state_e         state_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    irq_priority_enc u_prio (
        .req   (Src_State & mask_q),
        .idx   (win_idx),
        .valid (win_valid)
    );

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= StIdle;
            mask_q    <= RESET_MASK;
            IRQ       <= 1'b0;
            IRQ_Cause <= '0;
            Src_Clear <= '0;
            Pending   <= '0;
`ifdef IRQ_TIMEOUT_EN
            Timeout   <= 1'b0;
            tmo_cnt_q <= '0;
`endif
        end else begin
            Pending   <= Src_State & mask_q;
            Src_Clear <= '0;
            if (Mask_Write) begin
                mask_q <= Mask_Data;
            end

            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        IRQ_Cause <= win_idx;
                        IRQ       <= 1'b1;
                        state_q   <= StRequest;
`ifdef IRQ_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                StRequest: begin
                    if (IRQ_Ack) begin
                        IRQ     <= 1'b0;
                        state_q <= StService;
                    end
`ifdef IRQ_TIMEOUT_EN
                    // Abandon the request; the source stays set and is re-arbitrated.
                    else if (tmo_cnt_q == TMO_LAST) begin
                        IRQ     <= 1'b0;
                        Timeout <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                StService: begin
                    if (IRQ_Done) begin
                        Src_Clear <= NUM_SRC'(1) << IRQ_Cause;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifndef IRQ_TIMEOUT_EN
    assign Timeout = 1'b0;
`endif

    assign Busy = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed, table-driven bench for interrupt_dispatcher plus reset and timeout sequences.
module tb_interrupt_dispatcher;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] Src_State;
    logic       Mask_Write;
    logic [7:0] Mask_Data;
    logic       IRQ_Ack;
    logic       IRQ_Done;
    logic       IRQ;
    logic [2:0] IRQ_Cause;
    logic [7:0] Src_Clear;
    logic [7:0] Pending;
    logic       Busy;
    logic       Timeout;

    int checks   = 0;
    int failures = 0;

    interrupt_dispatcher #(
        .RESET_MASK     (8'hFF),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .Src_State  (Src_State),
        .Mask_Write (Mask_Write),
        .Mask_Data  (Mask_Data),
        .IRQ_Ack    (IRQ_Ack),
        .IRQ_Done   (IRQ_Done),
        .IRQ        (IRQ),
        .IRQ_Cause  (IRQ_Cause),
        .Src_Clear  (Src_Clear),
        .Pending    (Pending),
        .Busy       (Busy),
        .Timeout    (Timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [7:0] src;
        logic       mw;
        logic [7:0] md;
        logic       ack;
        logic       done;
        logic       irq;
        logic [2:0] cause;
        logic [7:0] clr;
        logic [7:0] pend;
        logic       busy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //           src    mw    md     ack   done  irq   cause  clr    pend   busy
        vecs[0]  = '{8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h30, 1'b1};
        vecs[1]  = '{8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h31, 1'b1};
        vecs[2]  = '{8'h31, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 8'h31, 1'b1};
        vecs[3]  = '{8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 8'h31, 1'b1};
        vecs[4]  = '{8'h31, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h10, 8'h31, 1'b1};
        vecs[5]  = '{8'h21, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 8'h21, 1'b0};
        vecs[6]  = '{8'h21, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h21, 1'b1};
        vecs[7]  = '{8'h21, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h21, 1'b1};
        vecs[8]  = '{8'h21, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 8'h21, 1'b1};
        vecs[9]  = '{8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h20, 1'b0};
        vecs[10] = '{8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{8'h0F, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h01, 1'b1};
        vecs[14] = '{8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h01, 1'b1};
        vecs[15] = '{8'h0F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1};

        CLR        = 1'b0;
        Src_State  = 8'h00;
        Mask_Write = 1'b0;
        Mask_Data  = 8'h00;
        IRQ_Ack    = 1'b0;
        IRQ_Done   = 1'b0;
        tick();
        tick();
        check("rst irq", IRQ, 1'b0);
        check("rst cause", IRQ_Cause, 3'd0);
        check("rst clr", Src_Clear, 8'h00);
        check("rst pend", Pending, 8'h00);
        check("rst busy", Busy, 1'b0);
        check("rst timeout", Timeout, 1'b0);
        CLR = 1'b1;

        for (int i = 0; i < 16; i++) begin
            Src_State  = vecs[i].src;
            Mask_Write = vecs[i].mw;
            Mask_Data  = vecs[i].md;
            IRQ_Ack    = vecs[i].ack;
            IRQ_Done   = vecs[i].done;
            tick();
            check($sformatf("v%0d irq", i), IRQ, vecs[i].irq);
            check($sformatf("v%0d cause", i), IRQ_Cause, vecs[i].cause);
            check($sformatf("v%0d clr", i), Src_Clear, vecs[i].clr);
            check($sformatf("v%0d pend", i), Pending, vecs[i].pend);
            check($sformatf("v%0d busy", i), Busy, vecs[i].busy);
            check($sformatf("v%0d timeout", i), Timeout, 1'b0);
        end

        // In SERVICE now: reset mid-cycle with Done raised must abort with no clear pulse.
        Mask_Write = 1'b0;
        IRQ_Ack    = 1'b0;
        #3;
        IRQ_Done = 1'b1;
        CLR      = 1'b0;
        #1;
        check("arst irq", IRQ, 1'b0);
        check("arst cause", IRQ_Cause, 3'd0);
        check("arst clr", Src_Clear, 8'h00);
        check("arst pend", Pending, 8'h00);
        check("arst busy", Busy, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("arst hold%0d clr", k), Src_Clear, 8'h00);
            check($sformatf("arst hold%0d busy", k), Busy, 1'b0);
        end
        CLR       = 1'b1;
        IRQ_Done  = 1'b0;
        Src_State = 8'h80;
        tick();
        check("post rst clr", Src_Clear, 8'h00);
        check("post rst irq", IRQ, 1'b1);
        check("post rst cause", IRQ_Cause, 3'd7);
        check("post rst pend", Pending, 8'h80);

`ifdef IRQ_TIMEOUT_EN
        for (int k = 1; k < 10; k++) begin
            tick();
            check($sformatf("tmo c%0d irq", k), IRQ, 1'b1);
            check($sformatf("tmo c%0d clr", k), Src_Clear, 8'h00);
        end
        tick();
        check("tmo irq fall", IRQ, 1'b0);
        check("tmo flag", Timeout, 1'b1);
        check("tmo busy", Busy, 1'b0);
        check("tmo clr", Src_Clear, 8'h00);
        tick();
        check("tmo rearb irq", IRQ, 1'b1);
        check("tmo sticky1", Timeout, 1'b1);
        IRQ_Ack = 1'b1;
        tick();
        IRQ_Ack = 1'b0;
        check("tmo ack irq", IRQ, 1'b0);
        check("tmo sticky2", Timeout, 1'b1);
`else
        repeat (300) tick();
        check("wait irq", IRQ, 1'b1);
        check("wait busy", Busy, 1'b1);
        check("wait timeout", Timeout, 1'b0);
        IRQ_Ack = 1'b1;
        tick();
        IRQ_Ack = 1'b0;
        check("wait ack irq", IRQ, 1'b0);
        check("wait ack timeout", Timeout, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
